sram_axi_bridge: RTL

Converts the core's two SRAM-like master ports (inst, data) into one AXI3 master port toward the system interconnect. Sits directly downstream of the CPU core and consumes its req/addr_ok/data_ok transactions. Provides read arbitration, one outstanding read per port, one outstanding write, and ID-based routing of read returns.

---
 rtl/sram_axi_bridge_pkg.sv | 38 +++
 rtl/sram_axi_bridge_if.sv | 77 +++++++
 rtl/sram_axi_wr_ch.sv | 110 +++++++++++
 rtl/sram_axi_bridge.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared IDs, FSM encodings, AXI constant fields and SRAM size codes for
// the SRAM-to-AXI3 bridge.
package sram_axi_bridge_pkg;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  typedef enum logic {
    AR_IDLE,
    AR_BUSY
  } ar_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } sram_size_e;

  // Single-beat incrementing bursts only; no locking, caching or protection.
  localparam logic [3:0] AXI_LEN   = 4'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  // The reserved size code is passed straight through rather than trapped.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// SRAM-like core port and AXI3 master port bundles used by the bridge.
interface sram_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wstrb, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wstrb, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

interface axi_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  input  arready,
                  input  rid, rdata, rresp, rlast, rvalid,
                  output rready,
                  output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                  input  awready,
                  output wid, wdata, wstrb, wlast, wvalid,
                  input  wready,
                  input  bid, bresp, bvalid,
                  output bready);
  modport slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                  output arready,
                  output rid, rdata, rresp, rlast, rvalid,
                  input  rready,
                  input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                  output awready,
                  input  wid, wdata, wstrb, wlast, wvalid,
                  output wready,
                  output bid, bresp, bvalid,
                  input  bready);
endinterface

// File: rtl/sram_axi_wr_ch.sv
// Write channel of the bridge: latches one data-port write and runs it
// through AW/W (independent handshakes) and then B.
module sram_axi_wr_ch
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        data_ok,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  wr_state_e   state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      WR_IDLE: begin
        if (accept) begin
          awaddr_d  = req_addr;
          awsize_d  = axi_size(req_size);
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_REQ;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, possibly in the same cycle.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WR_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign busy    = (state_q != WR_IDLE);
  assign bready  = (state_q == WR_RESP);
  assign data_ok = bready & bvalid;
  assign awid    = DATA_ID;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wid     = DATA_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// Two SRAM-like core ports (inst read-only, data read/write) onto one AXI3 master.
// Optional SRAM_AXI_PERF_EN adds read/write/stall performance counters.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic   clk,
  input  logic   reset,
  sram_if.slave  inst_sram,
  sram_if.slave  data_sram,
  axi_if.master  axi
`ifdef SRAM_AXI_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  ar_state_e   ar_state_q, ar_state_d;
  logic        inst_rd_pend_q, inst_rd_pend_d;
  logic        data_rd_pend_q, data_rd_pend_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;

  logic wr_busy, wr_data_ok, data_busy, ar_idle;
  logic data_rd_accept, wr_accept, inst_rd_accept;
  logic inst_ret, data_ret;

  assign data_busy = data_rd_pend_q | wr_busy;
  assign ar_idle   = (ar_state_q == AR_IDLE);

  // Data reads take priority over inst reads for the single AR slot.
  assign data_rd_accept = data_sram.req & ~data_sram.wr & ~data_busy & ar_idle;
  assign wr_accept      = data_sram.req & data_sram.wr & ~data_busy;
  assign inst_rd_accept = inst_sram.req & ~inst_rd_pend_q & ar_idle & ~data_rd_accept;

  // Gating on the pend flag drops returns for reads lost to a reset.
  assign inst_ret = axi.rvalid & (axi.rid == INST_ID) & inst_rd_pend_q;
  assign data_ret = axi.rvalid & (axi.rid == DATA_ID) & data_rd_pend_q;

  always_comb begin
    ar_state_d     = ar_state_q;
    inst_rd_pend_d = inst_rd_pend_q & ~inst_ret;
    data_rd_pend_d = data_rd_pend_q & ~data_ret;
    arvalid_d      = arvalid_q;
    araddr_d       = araddr_q;
    arsize_d       = arsize_q;
    arid_d         = arid_q;
    case (ar_state_q)
      AR_IDLE: begin
        if (data_rd_accept) begin
          araddr_d       = data_sram.addr;
          arsize_d       = axi_size(data_sram.size);
          arid_d         = DATA_ID;
          data_rd_pend_d = 1'b1;
          arvalid_d      = 1'b1;
          ar_state_d     = AR_BUSY;
        end else if (inst_rd_accept) begin
          araddr_d       = inst_sram.addr;
          arsize_d       = axi_size(inst_sram.size);
          arid_d         = INST_ID;
          inst_rd_pend_d = 1'b1;
          arvalid_d      = 1'b1;
          ar_state_d     = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (axi.arready) begin
          arvalid_d  = 1'b0;
          ar_state_d = AR_IDLE;
        end
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_state_q     <= AR_IDLE;
      inst_rd_pend_q <= 1'b0;
      data_rd_pend_q <= 1'b0;
      arvalid_q      <= 1'b0;
      araddr_q       <= '0;
      arsize_q       <= '0;
      arid_q         <= '0;
    end else begin
      ar_state_q     <= ar_state_d;
      inst_rd_pend_q <= inst_rd_pend_d;
      data_rd_pend_q <= data_rd_pend_d;
      arvalid_q      <= arvalid_d;
      araddr_q       <= araddr_d;
      arsize_q       <= arsize_d;
      arid_q         <= arid_d;
    end
  end

  sram_axi_wr_ch #(
    .DATA_ID (DATA_ID)
  ) u_wr_ch (
    .clk       (clk),
    .reset     (reset),
    .accept    (wr_accept),
    .req_size  (data_sram.size),
    .req_addr  (data_sram.addr),
    .req_wstrb (data_sram.wstrb),
    .req_wdata (data_sram.wdata),
    .busy      (wr_busy),
    .data_ok   (wr_data_ok),
    .awid      (axi.awid),
    .awaddr    (axi.awaddr),
    .awsize    (axi.awsize),
    .awvalid   (axi.awvalid),
    .awready   (axi.awready),
    .wid       (axi.wid),
    .wdata     (axi.wdata),
    .wstrb     (axi.wstrb),
    .wlast     (axi.wlast),
    .wvalid    (axi.wvalid),
    .wready    (axi.wready),
    .bvalid    (axi.bvalid),
    .bready    (axi.bready)
  );

  assign inst_sram.addr_ok = inst_rd_accept;
  assign inst_sram.data_ok = inst_ret;
  assign inst_sram.rdata   = axi.rdata;
  assign data_sram.addr_ok = data_rd_accept | wr_accept;
  assign data_sram.data_ok = data_ret | wr_data_ok;
  assign data_sram.rdata   = axi.rdata;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arsize  = arsize_q;
  assign axi.arvalid = arvalid_q;
  assign axi.arlen   = AXI_LEN;
  assign axi.arburst = AXI_BURST;
  assign axi.arlock  = AXI_LOCK;
  assign axi.arcache = AXI_CACHE;
  assign axi.arprot  = AXI_PROT;
  assign axi.rready  = 1'b1;
  assign axi.awlen   = AXI_LEN;
  assign axi.awburst = AXI_BURST;
  assign axi.awlock  = AXI_LOCK;
  assign axi.awcache = AXI_CACHE;
  assign axi.awprot  = AXI_PROT;

  logic unused_ok;
  assign unused_ok = ^{inst_sram.wr, inst_sram.wstrb, inst_sram.wdata,
                       axi.rresp, axi.rlast, axi.bid, axi.bresp};

`ifdef SRAM_AXI_PERF_EN
  logic [31:0] perf_rd_cnt_q, perf_rd_cnt_d;
  logic [31:0] perf_wr_cnt_q, perf_wr_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic        stall;

  // One stall tick per cycle, even when both ports are refused together.
  assign stall = (inst_sram.req & ~inst_sram.addr_ok) | (data_sram.req & ~data_sram.addr_ok);

  always_comb begin
    perf_rd_cnt_d    = perf_rd_cnt_q + {31'd0, axi.arvalid & axi.arready};
    perf_wr_cnt_d    = perf_wr_cnt_q + {31'd0, axi.bvalid & axi.bready};
    perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rd_cnt_q    <= '0;
      perf_wr_cnt_q    <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_rd_cnt_q    <= perf_rd_cnt_d;
      perf_wr_cnt_q    <= perf_wr_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_rd_cnt    = perf_rd_cnt_q;
  assign perf_wr_cnt    = perf_wr_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
